// File: rtl/chunk_mux_seq.sv
// Registered NUM_CH:1 chunk selector with an auto mode that captures the input
// bus on start and streams the chunks out in index order, one per cycle.
module chunk_mux_seq #(
  parameter int DATA_W = 4,
  parameter int NUM_CH = 2,
  parameter int SEL_W  = 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     mode,
  input  logic                     start,
  input  logic                     hold,
  input  logic [SEL_W-1:0]         sel,
  input  logic [NUM_CH*DATA_W-1:0] mux_in,
  output logic [DATA_W-1:0]        mux_out,
  output logic [SEL_W-1:0]         cur_sel,
  output logic                     out_valid,
  output logic                     busy,
  output logic                     done
);

  localparam logic [0:0]       ST_IDLE  = 1'b0;
  localparam logic [0:0]       ST_RUN   = 1'b1;
  localparam logic [SEL_W-1:0] LAST_IDX = SEL_W'(NUM_CH - 1);

  logic [0:0]              state_q,     state_d;
  logic [SEL_W-1:0]        idx_q,       idx_d;
  logic [NUM_CH*DATA_W-1:0] shadow_q,   shadow_d;
  logic [DATA_W-1:0]       mux_out_q,   mux_out_d;
  logic [SEL_W-1:0]        cur_sel_q,   cur_sel_d;
  logic                    out_valid_q, out_valid_d;
  logic                    busy_q,      busy_d;
  logic                    done_q,      done_d;

  // Indices at or beyond NUM_CH select zero rather than reading past the bus.
  function automatic logic [DATA_W-1:0] pick_chunk(
    input logic [NUM_CH*DATA_W-1:0] bus,
    input logic [SEL_W-1:0]         idx
  );
    logic [DATA_W-1:0] r;
    r = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (idx == SEL_W'(k)) begin
        r = bus[k*DATA_W +: DATA_W];
      end else begin
        r = r;
      end
    end
    return r;
  endfunction

  // Next-state and output selection
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    shadow_d    = shadow_q;
    mux_out_d   = mux_out_q;
    cur_sel_d   = cur_sel_q;
    out_valid_d = out_valid_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!mode) begin
          mux_out_d   = pick_chunk(mux_in, sel);
          cur_sel_d   = sel;
          out_valid_d = 1'b1;
        end else if (start) begin
          shadow_d    = mux_in;
          idx_d       = '0;
          busy_d      = 1'b1;
          out_valid_d = 1'b0;
          state_d     = ST_RUN;
        end else begin
          out_valid_d = 1'b0;
        end
      end
      ST_RUN: begin
        if (hold) begin
          out_valid_d = 1'b0;
        end else begin
          mux_out_d   = pick_chunk(shadow_q, idx_q);
          cur_sel_d   = idx_q;
          out_valid_d = 1'b1;
          // Compare against the last real channel so unused index codes never appear.
          if (idx_q == LAST_IDX) begin
            done_d  = 1'b1;
            busy_d  = 1'b0;
            idx_d   = '0;
            state_d = ST_IDLE;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      default: begin
        state_d     = ST_IDLE;
        idx_d       = '0;
        busy_d      = 1'b0;
        out_valid_d = 1'b0;
      end
    endcase
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      idx_q       <= '0;
      shadow_q    <= '0;
      mux_out_q   <= '0;
      cur_sel_q   <= '0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      shadow_q    <= shadow_d;
      mux_out_q   <= mux_out_d;
      cur_sel_q   <= cur_sel_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign mux_out   = mux_out_q;
  assign cur_sel   = cur_sel_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_chunk_mux_seq.sv
// Scoreboard bench for chunk_mux_seq: a 4-channel instance for auto/manual
// sequencing and a 3-channel instance for the out-of-range manual select.
module tb_chunk_mux_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, mode, start, hold;
  logic [1:0]  sel;
  logic [15:0] mux_in;
  logic [3:0]  mux_out;
  logic [1:0]  cur_sel;
  logic        out_valid, busy, done;

  logic        mode3, start3, hold3;
  logic [1:0]  sel3;
  logic [11:0] mux_in3;
  logic [3:0]  mux_out3;
  logic [1:0]  cur_sel3;
  logic        out_valid3, busy3, done3;

  chunk_mux_seq #(.DATA_W(4), .NUM_CH(4), .SEL_W(2)) u_dut (
    .clk(clk), .reset(reset), .mode(mode), .start(start), .hold(hold),
    .sel(sel), .mux_in(mux_in), .mux_out(mux_out), .cur_sel(cur_sel),
    .out_valid(out_valid), .busy(busy), .done(done)
  );

  chunk_mux_seq #(.DATA_W(4), .NUM_CH(3), .SEL_W(2)) u_dut3 (
    .clk(clk), .reset(reset), .mode(mode3), .start(start3), .hold(hold3),
    .sel(sel3), .mux_in(mux_in3), .mux_out(mux_out3), .cur_sel(cur_sel3),
    .out_valid(out_valid3), .busy(busy3), .done(done3)
  );

  typedef struct packed {
    logic [3:0] data;
    logic [1:0] sel;
    logic       done;
  } exp_t;

  exp_t q[$];
  exp_t q3[$];
  exp_t em, em3;
  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push(input logic [3:0] d, input logic [1:0] s, input logic dn);
    exp_t e;
    e.data = d; e.sel = s; e.done = dn;
    q.push_back(e);
  endtask

  task automatic push3(input logic [3:0] d, input logic [1:0] s);
    exp_t e;
    e.data = d; e.sel = s; e.done = 1'b0;
    q3.push_back(e);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Start a 4-chunk sequence; optionally wipe mux_in right after capture.
  task automatic run_seq(input logic [15:0] bus, input logic wipe);
    start  = 1'b1;
    mux_in = bus;
    cyc();
    start = 1'b0;
    if (wipe) mux_in = 16'h0000;
    chk("busy_after_start", {31'd0, busy}, 32'd1);
    chk("valid_after_start", {31'd0, out_valid}, 32'd0);
    for (int k = 0; k < 4; k++) push(bus[k*4 +: 4], 2'(k), (k == 3));
    for (int k = 0; k < 4; k++) begin
      cyc();
      chk("busy_in_seq", {31'd0, busy}, (k < 3) ? 32'd1 : 32'd0);
      chk("done_in_seq", {31'd0, done}, (k == 3) ? 32'd1 : 32'd0);
    end
  endtask

  // Monitor: every valid output pops and checks the head of its queue.
  always @(negedge clk) begin
    if (out_valid === 1'b1) begin
      if (q.size() == 0) begin
        total++; bad++;
        $display("FAIL main_unexpected_valid: got data %0h sel %0d expected no output", mux_out, cur_sel);
      end else begin
        em = q.pop_front();
        chk("main_data", {28'd0, mux_out}, {28'd0, em.data});
        chk("main_sel", {30'd0, cur_sel}, {30'd0, em.sel});
        chk("main_done", {31'd0, done}, {31'd0, em.done});
      end
    end else if (done === 1'b1) begin
      total++; bad++;
      $display("FAIL main_done_without_valid: got done 1 expected 0");
    end
    if (out_valid3 === 1'b1) begin
      if (q3.size() == 0) begin
        total++; bad++;
        $display("FAIL ch3_unexpected_valid: got data %0h sel %0d expected no output", mux_out3, cur_sel3);
      end else begin
        em3 = q3.pop_front();
        chk("ch3_data", {28'd0, mux_out3}, {28'd0, em3.data});
        chk("ch3_sel", {30'd0, cur_sel3}, {30'd0, em3.sel});
      end
    end
  end

  initial begin
    reset = 1'b1; mode = 1'b1; start = 1'b0; hold = 1'b0; sel = 2'd0; mux_in = 16'h0000;
    mode3 = 1'b1; start3 = 1'b0; hold3 = 1'b0; sel3 = 2'd0; mux_in3 = 12'h9C7;
    cyc(); cyc();
    chk("rst_mux_out", {28'd0, mux_out}, 32'd0);
    chk("rst_cur_sel", {30'd0, cur_sel}, 32'd0);
    chk("rst_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    reset = 1'b0;
    cyc();
    chk("idle_valid", {31'd0, out_valid}, 32'd0);

    // Manual select on the 4-channel instance.
    mux_in = 16'hD3A5; mode = 1'b0;
    sel = 2'd0; push(4'h5, 2'd0, 1'b0); cyc();
    sel = 2'd1; push(4'hA, 2'd1, 1'b0); cyc();
    sel = 2'd3; push(4'hD, 2'd3, 1'b0); cyc();
    mode = 1'b1; cyc();
    chk("manual_hold_data", {28'd0, mux_out}, 32'hD);
    chk("manual_hold_valid", {31'd0, out_valid}, 32'd0);

    // Plain auto sequence, then the retained last chunk.
    run_seq(16'hD3A5, 1'b0);
    cyc();
    chk("post_seq_data", {28'd0, mux_out}, 32'hD);
    chk("post_seq_done", {31'd0, done}, 32'd0);

    // Capture isolation, then a start issued in the done cycle.
    run_seq(16'hD3A5, 1'b1);
    run_seq(16'h4B6E, 1'b0);
    cyc();

    // Two hold cycles after chunk 1.
    start = 1'b1; mux_in = 16'hD3A5; cyc(); start = 1'b0;
    push(4'h5, 2'd0, 1'b0); push(4'hA, 2'd1, 1'b0);
    cyc(); cyc();
    hold = 1'b1;
    for (int k = 0; k < 2; k++) begin
      cyc();
      chk("hold_valid", {31'd0, out_valid}, 32'd0);
      chk("hold_data", {28'd0, mux_out}, 32'hA);
      chk("hold_sel", {30'd0, cur_sel}, 32'd1);
      chk("hold_busy", {31'd0, busy}, 32'd1);
    end
    hold = 1'b0;
    push(4'h3, 2'd2, 1'b0); push(4'hD, 2'd3, 1'b1);
    cyc();
    chk("hold_done_early", {31'd0, done}, 32'd0);
    cyc();
    chk("hold_done", {31'd0, done}, 32'd1);
    chk("hold_busy_end", {31'd0, busy}, 32'd0);
    cyc();

    // Reset while chunk 2 is presented, then a fresh replay.
    start = 1'b1; cyc(); start = 1'b0;
    push(4'h5, 2'd0, 1'b0); push(4'hA, 2'd1, 1'b0); push(4'h3, 2'd2, 1'b0);
    cyc(); cyc(); cyc();
    reset = 1'b1; cyc(); reset = 1'b0;
    chk("midrst_mux_out", {28'd0, mux_out}, 32'd0);
    chk("midrst_cur_sel", {30'd0, cur_sel}, 32'd0);
    chk("midrst_valid", {31'd0, out_valid}, 32'd0);
    chk("midrst_busy", {31'd0, busy}, 32'd0);
    chk("midrst_done", {31'd0, done}, 32'd0);
    for (int k = 0; k < 3; k++) begin
      cyc();
      chk("post_rst_done", {31'd0, done}, 32'd0);
      chk("post_rst_busy", {31'd0, busy}, 32'd0);
    end
    run_seq(16'hD3A5, 1'b0);
    cyc();

    // Manual select on the 3-channel instance, including unused code 3.
    mode3 = 1'b0;
    sel3 = 2'd0; push3(4'h7, 2'd0); cyc();
    sel3 = 2'd1; push3(4'hC, 2'd1); cyc();
    sel3 = 2'd2; push3(4'h9, 2'd2); cyc();
    sel3 = 2'd3; push3(4'h0, 2'd3); cyc();
    mode3 = 1'b1; cyc();
    chk("ch3_oor_data", {28'd0, mux_out3}, 32'd0);
    chk("ch3_idle_valid", {31'd0, out_valid3}, 32'd0);

    cyc(); cyc();
    chk("main_drain", q.size(), 32'd0);
    chk("ch3_drain", q3.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
